// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and memory.
// The LSU owns the request side; memory answers with ready and read data.
`timescale 1ns/1ps
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Execute-to-memory stage: turns the ALU result into a data-memory access,
// stalls the core while the access is outstanding, formats store lanes and
// strobes, and returns extended load data. Rejections and timeouts surface
// as flags during the single DONE cycle.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] timer;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        misalign_q;
  logic        bus_err_q;

  logic        access_req;
  logic        legal_f3;
  logic        aligned;
  logic        access_ok;
  logic        timer_expire;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  // Decode the instruction in execute: legality, alignment and store lanes
  always_comb begin
    access_req = ld_en | st_en;
    if (ld_en)
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    else
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    case (funct3[1:0])
      2'b01:   aligned = (addr[0] == 1'b0);
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    access_ok = legal_f3 && aligned;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wdata;
        st_strb = 4'b1111;
      end
    endcase
    timer_expire = (TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_CYCLES - 1);
  end

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    byte_sel = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_fmt = funct3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = funct3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_fmt = bus.mem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state; ready beats a timer expiring in the same cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (access_req) state_next = access_ok ? REQ : DONE;
      REQ:  if (bus.mem_ready || timer_expire) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; the request drops as soon as the state leaves REQ
  always_comb begin
    stall       = ((state == IDLE) && access_req) || (state == REQ);
    done        = (state == DONE);
    misalign    = (state == DONE) && misalign_q;
    bus_err     = (state == DONE) && bus_err_q;
    bus.mem_req = (state == REQ);
  end

  // Latch the bus transaction on accept, count REQ cycles, capture load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer         <= '0;
      is_load_q     <= 1'b0;
      funct3_q      <= '0;
      lane_q        <= '0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      rdata         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access_req) begin
            is_load_q  <= ld_en;
            funct3_q   <= funct3;
            lane_q     <= addr[1:0];
            timer      <= '0;
            misalign_q <= !access_ok;
            bus_err_q  <= 1'b0;
            if (access_ok) begin
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_we    <= !ld_en;
              bus.mem_wdata <= ld_en ? 32'h0 : st_data;
              bus.mem_wstrb <= ld_en ? 4'b0000 : st_strb;
            end else if (ld_en) begin
              rdata <= '0;
            end
          end
        end
        REQ: begin
          timer <= timer + 32'd1;
          if (bus.mem_ready) begin
            if (is_load_q) rdata <= load_fmt;
          end else if (timer_expire) begin
            bus_err_q <= 1'b1;
            if (is_load_q) rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 4-cycle timeout.
// The bench plays the memory by driving ready/rdata directly.
`timescale 1ns/1ps
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en, st_en;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign, bus_err;
  logic [31:0] rdata;
  int          compared = 0;
  int          mismatched = 0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
    .misalign(misalign), .bus_err(bus_err), .bus(bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    ld_en  = ld;
    st_en  = st;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    #3;
    checkOutput("rst_req", bus.mem_req, 1'b0);
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_wstrb", bus.mem_wstrb, 4'h0);
    checkOutput("rst_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();

    // LW aligned, ready in the first REQ cycle
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("lw_c1_stall", stall, 1'b1);
    checkOutput("lw_c1_req", bus.mem_req, 1'b0);
    nextCycle();
    checkOutput("lw_c2_stall", stall, 1'b1);
    checkOutput("lw_c2_req", bus.mem_req, 1'b1);
    checkOutput("lw_addr", bus.mem_addr, 32'h0000_1000);
    checkOutput("lw_wstrb", bus.mem_wstrb, 4'h0);
    checkOutput("lw_we", bus.mem_we, 1'b0);
    checkOutput("lw_c2_done", done, 1'b0);
    nextCycle();
    checkOutput("lw_c3_done", done, 1'b1);
    checkOutput("lw_c3_stall", stall, 1'b0);
    checkOutput("lw_rdata", rdata, 32'hDEAD_BEEF);
    checkOutput("lw_misalign", misalign, 1'b0);
    idleCycle();
    checkOutput("lw_done_clear", done, 1'b0);

    // Byte/half loads from word 0x80FF0000
    bus.mem_rdata = 32'h80FF_0000;
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    nextCycle();
    checkOutput("lb_addr", bus.mem_addr, 32'h0000_1000);
    nextCycle();
    checkOutput("lb_rdata", rdata, 32'hFFFF_FF80);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("lbu_rdata", rdata, 32'h0000_0080);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("lhu_rdata", rdata, 32'h0000_80FF);
    idleCycle();

    // Stores: lane replication and strobes; rdata untouched
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678);
    nextCycle();
    checkOutput("sb_req", bus.mem_req, 1'b1);
    checkOutput("sb_we", bus.mem_we, 1'b1);
    checkOutput("sb_addr", bus.mem_addr, 32'h0000_2000);
    checkOutput("sb_wdata", bus.mem_wdata, 32'h7878_7878);
    checkOutput("sb_wstrb", bus.mem_wstrb, 4'b0010);
    nextCycle();
    checkOutput("sb_done", done, 1'b1);
    checkOutput("sb_rdata_kept", rdata, 32'h0000_80FF);
    idleCycle();
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678);
    nextCycle();
    checkOutput("sh_wdata", bus.mem_wdata, 32'h5678_5678);
    checkOutput("sh_wstrb", bus.mem_wstrb, 4'b1100);
    checkOutput("sh_we", bus.mem_we, 1'b1);
    nextCycle();
    checkOutput("sh_done", done, 1'b1);
    idleCycle();

    // Misaligned LW: one stall cycle, no request, rdata cleared
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0);
    #1;
    checkOutput("mis_lw_stall", stall, 1'b1);
    checkOutput("mis_lw_req0", bus.mem_req, 1'b0);
    nextCycle();
    checkOutput("mis_lw_req1", bus.mem_req, 1'b0);
    checkOutput("mis_lw_done", done, 1'b1);
    checkOutput("mis_lw_flag", misalign, 1'b1);
    checkOutput("mis_lw_stall_done", stall, 1'b0);
    checkOutput("mis_lw_rdata", rdata, 32'h0);
    idleCycle();
    checkOutput("mis_flag_clear", misalign, 1'b0);

    // Store with illegal funct3
    applyStimulus(1'b0, 1'b1, 3'b011, 32'h0000_2000, 32'hAAAA_5555);
    #1;
    checkOutput("ill_sw_stall", stall, 1'b1);
    nextCycle();
    checkOutput("ill_sw_req", bus.mem_req, 1'b0);
    checkOutput("ill_sw_done", done, 1'b1);
    checkOutput("ill_sw_flag", misalign, 1'b1);
    idleCycle();

    // Ready arrives in the 4th REQ cycle, the same cycle the timer expires
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hCAFE_F00D;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      checkOutput($sformatf("late_req_%0d", i), bus.mem_req, 1'b1);
    end
    nextCycle();
    bus.mem_ready = 1'b1;
    #1;
    checkOutput("late_req_4", bus.mem_req, 1'b1);
    nextCycle();
    checkOutput("late_done", done, 1'b1);
    checkOutput("late_bus_err", bus_err, 1'b0);
    checkOutput("late_rdata", rdata, 32'hCAFE_F00D);
    idleCycle();

    // Timeout: ready never comes
    bus.mem_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      checkOutput($sformatf("to_req_%0d", i), bus.mem_req, 1'b1);
      checkOutput($sformatf("to_stall_%0d", i), stall, 1'b1);
    end
    nextCycle();
    checkOutput("to_req_dropped", bus.mem_req, 1'b0);
    checkOutput("to_done", done, 1'b1);
    checkOutput("to_bus_err", bus_err, 1'b1);
    checkOutput("to_rdata", rdata, 32'h0);
    idleCycle();
    checkOutput("to_err_clear", bus_err, 1'b0);

    // Reset in the middle of REQ; the core is flushed alongside
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0);
    nextCycle();
    checkOutput("rr_req_before", bus.mem_req, 1'b1);
    #2;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("rr_req", bus.mem_req, 1'b0);
    checkOutput("rr_stall", stall, 1'b0);
    checkOutput("rr_done", done, 1'b0);
    checkOutput("rr_misalign", misalign, 1'b0);
    checkOutput("rr_bus_err", bus_err, 1'b0);
    checkOutput("rr_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1122_3344;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0);
    nextCycle();
    checkOutput("rr_lw_req", bus.mem_req, 1'b1);
    nextCycle();
    checkOutput("rr_lw_done", done, 1'b1);
    checkOutput("rr_lw_rdata", rdata, 32'h1122_3344);
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execute-to-memory stage placed directly downstream of the ALU: takes the ALU result as the effective address for load/store instructions and runs a valid/ready transaction on the data-memory bus. It stalls the core for the duration of the access and generates byte strobes and lane-replicated write data. It returns sign- or zero-extended load data to writeback. Misaligned addresses, illegal size codes and bus timeouts are reported as one-cycle flags.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in REQ before the access is aborted; 0 disables the timeout.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ld_en` in 1: a load instruction is in execute.
- `st_en` in 1: a store instruction is in execute.
- `funct3` in 3: access size/sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr` in 32: effective address (ALU result).
- `wdata` in 32: store source (rs2).
- `stall` out 1: freezes PC and instruction while asserted.
- `rdata` out 32: formatted load result.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: access rejected for misalignment or an illegal funct3.
- `bus_err` out 1: access aborted by timeout.
- `mem_req` out 1: bus request.
- `mem_we` out 1: write enable (1 = store).
- `mem_addr` out 32: word address `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte strobes (0 for loads).
- `mem_ready` in 1: memory accepts or completes the access this cycle.
- `mem_rdata` in 32: read word; valid when `mem_ready` is high.

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- **IDLE**
  - If `ld_en` or `st_en` is high, decode and check the access. If both are high, the load wins.
  - Illegal funct3 (loads 011, 110, 111; stores anything other than 000/001/010) → go to DONE with `misalign` set. No bus request is issued.
  - Halfword with `addr[0]`=1, or word with `addr[1:0]`≠0 → same as illegal funct3.
  - Otherwise latch `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb`, clear the timer, and go to REQ.
- **REQ**
  - `mem_req`=1. All bus outputs are held stable until `mem_ready` is sampled high.
  - On `mem_ready`: for loads, register the formatted `mem_rdata` into `rdata`; then go to DONE.
  - The timer increments each REQ cycle. If it reaches `TIMEOUT_CYCLES` with `mem_ready` low, drop `mem_req`, set `bus_err`, and go to DONE.
  - If `mem_ready` arrives on the same cycle the timer expires, `mem_ready` wins.
- **DONE**
  - `done`=1 and `stall`=0, so the core advances on this edge.
  - Always return to IDLE. `ld_en`/`st_en` from the same, still-present instruction are ignored.
  - `misalign` and `bus_err` are high only in DONE.
- **Stores**
  - SB: `wdata[7:0]` replicated into all four lanes; `wstrb = 4'b0001 << addr[1:0]`.
  - SH: `wdata[15:0]` replicated into both halves; `wstrb` = 0011 if `addr[1]`=0, else 1100.
  - SW: `wstrb` = 1111.
- **Loads**
  - Byte lane is selected by `addr[1:0]`, half lane by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **`rdata`**
  - Holds its value until the next successful load completes.
  - Cleared to 0 on a load that ends in `misalign` or `bus_err`.
  - Unchanged by stores.
- **`stall`** is combinational: `(IDLE && (ld_en||st_en)) || REQ`.

## Timing
- **Reset** (asynchronous, immediate):
  - State → IDLE; timer → 0.
  - `rdata` → 0.
  - `done`, `misalign`, `bus_err`, `mem_req`, `mem_we` → 0.
  - `mem_addr`, `mem_wdata` → 0; `mem_wstrb` → 0.
  - Reset during REQ drops `mem_req` without waiting for `mem_ready`.
- **Minimum latency** (`mem_ready` high in the first REQ cycle): accept cycle (IDLE) + one REQ cycle. `stall` is high for 2 cycles and `done` pulses on cycle 3.
- **Slow memory**: each extra wait cycle adds one cycle of `stall`.
- **Rejected access**: `stall` is high for 1 cycle, then DONE.
- **Maximum REQ dwell** is `TIMEOUT_CYCLES` cycles.
- **Back-to-back**: a new access is accepted no earlier than the IDLE cycle following DONE.

## Test plan
- **LW aligned:**
  - Stimulus: `addr`=0x1000, memory returns 0xDEADBEEF with `ready` in the first REQ cycle.
  - Expected: `mem_addr`=0x1000, `wstrb`=0, `stall` high 2 cycles, `done` on cycle 3, `rdata`=0xDEADBEEF.
- **Byte loads:**
  - LB at 0x1003 with word 0x80FF_0000 → `rdata`=0xFFFFFF80.
  - LBU at 0x1003 → 0x00000080.
  - LHU at 0x1002 → 0x000080FF.
- **Stores:**
  - SB at 0x2001 with `wdata`=0x12345678 → `wdata`=0x78787878, `wstrb`=0010, `mem_we`=1.
  - SH at 0x2002 → `wdata`=0x56785678, `wstrb`=1100.
- **Misalignment:**
  - LW at 0x1002 → no `mem_req`, `stall` 1 cycle, then `done`=1 with `misalign`=1, `rdata`=0.
  - SW with funct3=011 → same response.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=4, `mem_ready` held low.
  - Expected: `mem_req` high for exactly 4 cycles, then `done`=1 with `bus_err`=1.
  - Rerun with `ready` on the 4th cycle → normal completion, `bus_err`=0.
- **Reset mid-access:** assert `rst` during REQ → `mem_req`, `stall` and all flags go to 0 immediately; after release, a fresh LW completes normally.
